// File: rtl/rsa_decode_ctrl.sv
// Byte-stream front end and sequencer for the RSA decoder: frames 2-byte ciphertext words,
// range-checks them, runs the decoder under a watchdog and streams back the 2-byte plaintext.
module rsa_decode_ctrl #(
  parameter int unsigned k       = 12,
  parameter int unsigned n       = 3551,
  parameter int unsigned TIMEOUT = 65535,
  parameter int unsigned TW      = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  output logic         dec_start,
  output logic [k-1:0] dec_data_in,
  input  logic [k-1:0] dec_data_out,
  input  logic         dec_done,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_byte,
  output logic         err,
  output logic         busy
);

  localparam int unsigned FW = 16;

  typedef enum logic [2:0] {
    GET_HI  = 3'd0,
    GET_LO  = 3'd1,
    CHECK   = 3'd2,
    START   = 3'd3,
    WAIT    = 3'd4,
    SEND_HI = 3'd5,
    SEND_LO = 3'd6
  } state_t;

  state_t         state, state_d;
  logic [7:0]     hi_reg, hi_d;
  logic [k-1:0]   word_q, word_d;
  logic [k-1:0]   result, result_d;
  logic [TW-1:0]  wd, wd_d, wd_inc_c;
  logic [FW-1:0]  frame_c;
  logic           reject_c;
  logic           in_ready_d, dec_start_d, out_valid_d, err_d, busy_d;
  logic [k-1:0]   dec_data_in_d;
  logic [7:0]     out_byte_d;

  // Frame check is evaluated on the low-byte handshake so err lands in the CHECK cycle
  assign frame_c  = {hi_reg, in_byte};
  assign reject_c = ((frame_c >> k) != FW'(0)) || (k'(frame_c) >= k'(n));
  assign wd_inc_c = wd + TW'(1);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= GET_HI;
      hi_reg      <= '0;
      word_q      <= '0;
      result      <= '0;
      wd          <= '0;
      in_ready    <= 1'b0;
      dec_start   <= 1'b0;
      dec_data_in <= '0;
      out_valid   <= 1'b0;
      out_byte    <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      hi_reg      <= hi_d;
      word_q      <= word_d;
      result      <= result_d;
      wd          <= wd_d;
      in_ready    <= in_ready_d;
      dec_start   <= dec_start_d;
      dec_data_in <= dec_data_in_d;
      out_valid   <= out_valid_d;
      out_byte    <= out_byte_d;
      err         <= err_d;
      busy        <= busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state;
    hi_d          = hi_reg;
    word_d        = word_q;
    result_d      = result;
    wd_d          = wd;
    dec_start_d   = 1'b0;
    dec_data_in_d = dec_data_in;
    out_valid_d   = out_valid;
    out_byte_d    = out_byte;
    err_d         = 1'b0;

    case (state)
      GET_HI: begin
        if (in_valid && in_ready) begin
          hi_d    = in_byte;
          state_d = GET_LO;
        end
      end
      GET_LO: begin
        if (in_valid && in_ready) begin
          word_d  = k'(frame_c);
          err_d   = reject_c;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // err is high exactly when this frame was rejected
        if (err) begin
          state_d = GET_HI;
        end else begin
          dec_data_in_d = word_q;
          dec_start_d   = 1'b1;
          state_d       = START;
        end
      end
      START: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (dec_done) begin
          result_d    = dec_data_out;
          out_valid_d = 1'b1;
          out_byte_d  = 8'(dec_data_out >> 8);
          state_d     = SEND_HI;
        end else if (wd_inc_c == TW'(TIMEOUT)) begin
          wd_d    = '0;
          err_d   = 1'b1;
          state_d = GET_HI;
        end else begin
          wd_d = wd_inc_c;
        end
      end
      SEND_HI: begin
        if (out_ready) begin
          out_byte_d = result[7:0];
          state_d    = SEND_LO;
        end
      end
      SEND_LO: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_byte_d  = '0;
          state_d     = GET_HI;
        end
      end
      default: state_d = GET_HI;
    endcase

    in_ready_d = (state_d == GET_HI) || (state_d == GET_LO);
    busy_d     = (state_d != GET_HI);
  end

endmodule
